// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Shares one active-low status LED between NUM_REQ requesters. A granted
//   requester gets a burst of blink_count[i] ON/OFF blinks, followed by
//   GAP_TICKS dark ticks, then a one-cycle done pulse. All phase timing is
//   advanced by the external single-cycle 'tick' pulse.
//
//   Build option:
//     LED_BLINK_FIXED_PRIO_EN  defined   -> lowest set req index always wins
//                                           (no round-robin pointer register)
//                              undefined -> round-robin arbitration
//
//   Ports:
//     clk          system clock
//     nRst         synchronous active-low reset
//     tick         one-cycle timing pulse, one tick per LED phase
//     req          per-requester request level
//     blink_count  count for requester i in bits [i*CNT_W +: CNT_W]
//     grant        one-hot owner of the LED, zero when idle
//     done         one-cycle completion pulse to the owner
//     busy         high whenever not idle
//     nLED         active-low LED drive, low only while in ON
module led_blink_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     tick,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_count,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     nLED
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q,  done_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic               abort_q, abort_d;
`ifndef LED_BLINK_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
`endif

  // Per-requester view of the packed count bus.
  logic [CNT_W-1:0] cnt_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign cnt_arr[g] = blink_count[g*CNT_W +: CNT_W];
  end

  // Winner selection.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [CNT_W-1:0] win_count;

`ifdef LED_BLINK_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[IDX_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`else
  int unsigned cand;

  // Search starts one past the last owner so a requester that holds req
  // high cannot win again while anyone else is waiting.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end
`endif

  assign win_count = cnt_arr[win_idx];

  logic owner_req;
  assign owner_req = |(req & grant_q);

  // Next-state logic. Each branch consumes at most one tick, so a tick on a
  // transition edge is never seen again by the state being entered.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    remain_d = remain_q;
    gap_d    = gap_q;
    abort_d  = abort_q;
`ifndef LED_BLINK_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = NUM_REQ'(1) << win_idx;
          remain_d = win_count;
          abort_d  = 1'b0;
`ifndef LED_BLINK_FIXED_PRIO_EN
          ptr_d    = win_idx;
`endif
          if (win_count == '0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_TICKS);
          end else begin
            state_d = S_ON;
          end
        end
      end

      S_ON: begin
        if (!owner_req) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_TICKS);
          abort_d = 1'b1;
        end else if (tick) begin
          state_d = S_OFF;
        end
      end

      S_OFF: begin
        if (!owner_req) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_TICKS);
          abort_d = 1'b1;
        end else if (tick) begin
          if (remain_q <= CNT_W'(1)) begin
            remain_d = '0;
            state_d  = S_GAP;
            gap_d    = GAP_W'(GAP_TICKS);
          end else begin
            remain_d = remain_q - CNT_W'(1);
            state_d  = S_ON;
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (gap_q <= GAP_W'(1)) begin
            gap_d   = '0;
            state_d = S_IDLE;
            grant_d = '0;
            done_d  = abort_q ? '0 : grant_q;
            abort_d = 1'b0;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      remain_q <= '0;
      gap_q    <= '0;
      abort_q  <= 1'b0;
`ifndef LED_BLINK_FIXED_PRIO_EN
      ptr_q    <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      remain_q <= remain_d;
      gap_q    <= gap_d;
      abort_q  <= abort_d;
`ifndef LED_BLINK_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);
  assign nLED  = (state_q != S_ON);

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
- Shares the single board status LED between NUM_REQ requesters.
- Each requester asks for a burst of N blinks; the arbiter grants one requester at a time, round-robin.
- It plays the burst, holds a dark gap, then signals completion.
- Timing comes from an external one-cycle tick pulse, normally the divided pulse output of the Hz clock divider, so blink rate is set by that divider's FREQUENCY.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, width of each requester's blink count.
- GAP_TICKS, 4, dark ticks inserted after each burst (>=1).

Ports:
- clk  input  1  system clock.
- nRst  input  1  synchronous active-low reset.
- tick  input  1  single-cycle timing pulse; one tick = one LED phase.
- req  input  NUM_REQ  per-requester request level.
- blink_count  input  NUM_REQ*CNT_W  blink count for requester i in bits [i*CNT_W +: CNT_W].
- grant  output  NUM_REQ  one-hot owner of LED, zero when idle.
- done  output  NUM_REQ  one-cycle completion pulse to requester i.
- busy  output  1  high whenever state != IDLE.
- nLED  output  1  active-low LED drive.

Behaviour:
- Reset (nRst low at a clk edge), next-cycle values:
  - state=IDLE; grant=0; done=0; busy=0; nLED=1.
  - Round-robin pointer = NUM_REQ-1, so index 0 wins first.
  - Reset mid-burst aborts immediately with no done pulse.
- States and transitions:
  - IDLE: a cycle with any req high selects the winner. The winner is the first set req index strictly after the pointer, wrapping. Next cycle:
    - grant = winner.
    - Remaining count latched from blink_count.
    - Pointer = winner.
    - If the latched count is 0, go to GAP; otherwise go to ON.
  - ON: nLED=0. The first tick seen in ON goes to OFF.
    - The first ON phase is 1 cycle to one tick period long, depending on tick phase. This is accepted.
  - OFF: nLED=1. On tick, decrement remaining.
    - Remaining becomes 0: go to GAP, gap counter = GAP_TICKS.
    - Otherwise: go to ON.
  - GAP: nLED=1. Each tick decrements the gap counter. When it reaches 0:
    - done[owner] pulses for exactly one cycle.
    - grant clears in the same cycle.
    - Return to IDLE.
- Arbitration:
  - IDLE lasts at least 1 cycle between grants; back-to-back bursts are separated by exactly one IDLE cycle.
  - A requester holding req high continuously after done does not win again while any other req is high.
- Abort:
  - If req[owner] drops during ON or OFF, go to GAP with nLED=1 on the next cycle.
  - The gap still runs, but done is NOT pulsed at its end; grant clears when the gap ends.
  - Dropping req during GAP has no effect on done.
- Sampling:
  - blink_count is sampled only at grant; later changes are ignored for the current burst.
  - req is sampled only in IDLE (plus the owner's abort check).
- Tick handling:
  - A tick in the same cycle as a state transition is consumed by the state being left. It is not counted twice.
  - A tick during IDLE is ignored.
- Guarantees:
  - grant is always one-hot or zero.
  - done is only ever set for the current owner.
  - nLED=0 only in ON.

Optional Feature:
- LED_BLINK_FIXED_PRIO_EN
  - Defined: fixed priority, lowest set req index always wins. The pointer register is not implemented.
  - Undefined: round-robin as above.
  - All other behaviour is identical in both cases.

Test Plan:
- Reset, then req=4'b0001 with count0=3 and tick every 10 cycles:
  - 3 ON phases with nLED=0, each ending on a tick.
  - After the 3rd OFF, 4 gap ticks.
  - done[0] pulses once; grant returns to 0; busy falls the same cycle as grant.
- req=4'b1111 held high, all counts=1:
  - Grants occur in order 0,1,2,3,0; each is separated from the previous one by its gap plus exactly 1 IDLE cycle.
  - Repeat with LED_BLINK_FIXED_PRIO_EN defined: grant stays on index 0 every time.
- req=4'b0100 with count2=0:
  - Grant 4'b0100 and no nLED=0 cycle.
  - done[2] pulses after 4 gap ticks.
- Owner 1 granted with count=5; drop req[1] after the 2nd ON phase:
  - nLED=1 the next cycle.
  - The 4-tick gap runs, done stays 0, grant clears, then IDLE.
- Assert nRst=0 for one cycle mid-ON:
  - Next cycle nLED=1, grant=0, busy=0, no done pulse.
  - A following req=4'b1000 is granted to index 3 (pointer reset to 3 makes 0 first only when req0 is set).
- Tick coincident with the grant cycle, and tick held continuously high:
  - With tick held high, each ON/OFF/GAP phase lasts exactly 1 cycle.
  - With count=2, nLED reads 0,1,0,1 followed by 4 dark cycles and done.
